// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the serial pattern detector.
// Optional timeout support is enabled by defining SEQ_DET_TIMEOUT_EN.
package seq_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [2:0]  RST_PAT = 3'b111;
   localparam logic [3:0]  RST_LEN = 4'd3;
   localparam int unsigned RST_TGT = 32'd1;

   // A zero length means a single-bit pattern; longer than the register clamps to its width.
   function automatic logic [3:0] clamp_len(input logic [3:0] len, input int pat_w);
      logic [3:0] res;
      if (len == 4'd0) begin
         res = 4'd1;
      end else if (int'({28'd0, len}) > pat_w) begin
         res = pat_w[3:0];
      end else begin
         res = len;
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_match.sv
// Shift register, saturating bit counter and masked pattern compare.
// match is combinational and fires on the beat that completes the pattern.
module seq_match
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             in_bit,
   input  logic [PAT_W-1:0] pat,
   input  logic [3:0]       len,
   output logic             match
);

   logic [PAT_W-1:0] sr_q;
   logic [PAT_W-1:0] sr_d;
   logic [PAT_W-1:0] sr_shift_s;
   logic [PAT_W-1:0] mask_s;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_d;
   logic [3:0]       cnt_inc_s;

   // Compare the post-shift register so the match lines up with the sampled beat.
   always_comb begin
      mask_s     = {PAT_W{1'b0}};
      sr_shift_s = {sr_q[PAT_W-2:0], in_bit};
      cnt_inc_s  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      for (int i = 0; i < PAT_W; i++) begin
         mask_s[i] = (i < int'(len));
      end
      match = shift && (cnt_inc_s >= len) &&
              (((sr_shift_s ^ pat) & mask_s) == {PAT_W{1'b0}});
   end

   // Next-state for history register and bit counter.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clr) begin
         sr_d  = {PAT_W{1'b0}};
         cnt_d = 4'd0;
      end else if (shift) begin
         sr_d  = sr_shift_s;
         cnt_d = cnt_inc_s;
      end else begin
         sr_d  = sr_q;
         cnt_d = cnt_q;
      end
   end

   // History state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= {PAT_W{1'b0}};
         cnt_q <= 4'd0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: arm, count matches, finish, acknowledge.
// Define SEQ_DET_TIMEOUT_EN to build the in_vld-beat timeout.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int TO_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_vld,
   input  logic             cfg_wr,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic [3:0]       cfg_len,
   input  logic [CNT_W-1:0] cfg_tgt,
   input  logic [TO_W-1:0]  cfg_to,
   input  logic             start,
   input  logic             abort,
   input  logic             ack,
   output logic             busy,
   output logic             det,
   output logic             done,
   output logic             hit,
   output logic             tmo,
   output logic [CNT_W-1:0] hit_cnt
);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [3:0]       len_q, len_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic             det_q, det_d;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] tgt_eff_s;
   logic [CNT_W-1:0] hit_cnt_inc_s;
   logic             arm_s;
   logic             shift_s;
   logic             match_s;
   logic             target_s;
   logic             to_expire_s;

   assign arm_s         = (state_q == ST_IDLE) && start;
   assign shift_s       = (state_q == ST_RUN) && !abort && in_vld;
   assign tgt_eff_s     = (tgt_q == {CNT_W{1'b0}}) ? CNT_W'(1) : tgt_q;
   assign hit_cnt_inc_s = (hit_cnt_q == {CNT_W{1'b1}}) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
   assign target_s      = match_s && (hit_cnt_inc_s == tgt_eff_s);

   seq_match #(
      .PAT_W (PAT_W)
   ) u_match (
      .clk    (clk),
      .rst    (rst),
      .clr    (arm_s),
      .shift  (shift_s),
      .in_bit (in),
      .pat    (pat_q),
      .len    (len_q),
      .match  (match_s)
   );

`ifdef SEQ_DET_TIMEOUT_EN
   logic [TO_W-1:0] to_lim_q, to_lim_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            tmo_q, tmo_d;

   // Beat counter; a target hit on the expiring beat takes precedence over timeout.
   always_comb begin
      to_lim_d    = to_lim_q;
      to_cnt_d    = to_cnt_q;
      tmo_d       = tmo_q;
      to_expire_s = 1'b0;
      if ((state_q == ST_IDLE) && cfg_wr) begin
         to_lim_d = cfg_to;
      end else begin
         to_lim_d = to_lim_q;
      end
      if (arm_s) begin
         to_cnt_d = {TO_W{1'b0}};
         tmo_d    = 1'b0;
      end else if (shift_s) begin
         to_cnt_d    = to_cnt_q + TO_W'(1);
         to_expire_s = (to_lim_q != {TO_W{1'b0}}) && (to_cnt_d == to_lim_q);
         if (to_expire_s && !target_s) begin
            tmo_d = 1'b1;
         end else begin
            tmo_d = tmo_q;
         end
      end else begin
         to_cnt_d = to_cnt_q;
      end
   end

   // Timeout state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_lim_q <= {TO_W{1'b0}};
         to_cnt_q <= {TO_W{1'b0}};
         tmo_q    <= 1'b0;
      end else begin
         to_lim_q <= to_lim_d;
         to_cnt_q <= to_cnt_d;
         tmo_q    <= tmo_d;
      end
   end

   assign tmo = tmo_q;
`else
   logic cfg_to_unused;
   assign cfg_to_unused = ^cfg_to;
   assign to_expire_s   = 1'b0;
   assign tmo           = 1'b0;
`endif

   // Run FSM, configuration capture and match bookkeeping; abort wins over everything.
   always_comb begin
      state_d   = state_q;
      det_d     = 1'b0;
      hit_cnt_d = hit_cnt_q;
      hit_d     = hit_q;
      pat_d     = pat_q;
      len_d     = len_q;
      tgt_d     = tgt_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_wr) begin
               pat_d = cfg_pat;
               len_d = clamp_len(cfg_len, PAT_W);
               tgt_d = cfg_tgt;
            end else begin
               pat_d = pat_q;
               len_d = len_q;
               tgt_d = tgt_q;
            end
            if (start) begin
               state_d   = ST_ARMED;
               hit_cnt_d = {CNT_W{1'b0}};
               hit_d     = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (target_s) begin
               state_d   = ST_DONE;
               det_d     = 1'b1;
               hit_cnt_d = hit_cnt_inc_s;
               hit_d     = 1'b1;
            end else begin
               state_d   = to_expire_s ? ST_DONE : ST_RUN;
               det_d     = match_s;
               hit_cnt_d = match_s ? hit_cnt_inc_s : hit_cnt_q;
            end
         end
         ST_DONE: begin
            if (ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         det_q     <= 1'b0;
         hit_q     <= 1'b0;
         hit_cnt_q <= {CNT_W{1'b0}};
         pat_q     <= PAT_W'(RST_PAT);
         len_q     <= RST_LEN;
         tgt_q     <= CNT_W'(RST_TGT);
      end else begin
         state_q   <= state_d;
         det_q     <= det_d;
         hit_q     <= hit_d;
         hit_cnt_q <= hit_cnt_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         tgt_q     <= tgt_d;
      end
   end

   assign busy    = (state_q == ST_ARMED) || (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign det     = det_q;
   assign hit     = hit_q;
   assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed and randomized bench for seq_det_ctrl against a bit-history reference model.
module tb_seq_det_ctrl;

   localparam int PAT_W = 8;
   localparam int CNT_W = 8;
   localparam int TO_W  = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in = 1'b0;
   logic             in_vld = 1'b0;
   logic             cfg_wr = 1'b0;
   logic [PAT_W-1:0] cfg_pat = '0;
   logic [3:0]       cfg_len = '0;
   logic [CNT_W-1:0] cfg_tgt = '0;
   logic [TO_W-1:0]  cfg_to = '0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             ack = 1'b0;
   logic             busy, det, done, hit, tmo;
   logic [CNT_W-1:0] hit_cnt;

   int n_chk = 0;
   int n_err = 0;

   // reference model: run phase flags plus raw history of sampled bits
   bit         m_armed, m_run, m_done, m_hit, m_tmo, m_det;
   int         m_hits, m_beats;
   bit         hist[$];
   logic [7:0] m_pat;
   int         m_len, m_tgt, m_to;

   seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .in(in), .in_vld(in_vld), .cfg_wr(cfg_wr),
      .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_tgt(cfg_tgt), .cfg_to(cfg_to),
      .start(start), .abort(abort), .ack(ack), .busy(busy), .det(det),
      .done(done), .hit(hit), .tmo(tmo), .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".busy"}, 32'(busy), 32'(m_armed || m_run));
      chk({tag, ".det"}, 32'(det), 32'(m_det));
      chk({tag, ".done"}, 32'(done), 32'(m_done));
      chk({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(m_hits));
      if (m_done) begin
         chk({tag, ".hit"}, 32'(hit), 32'(m_hit));
         chk({tag, ".tmo"}, 32'(tmo), 32'(m_tmo));
      end
   endtask

   function automatic bit model_match();
      if (hist.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         if (hist[hist.size() - 1 - i] != m_pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_vld = 1'b1; in = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_vld = 1'b0; in = 1'b0;
      m_armed = 0; m_run = 0; m_done = 0; m_hit = 0; m_tmo = 0; m_det = 0;
      m_hits = 0; m_beats = 0; hist.delete();
      m_pat = 8'h07; m_len = 3; m_tgt = 1; m_to = 0;
      check_all("rst");
      chk("rst.hit", 32'(hit), 32'd0);
      chk("rst.tmo", 32'(tmo), 32'd0);
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t,
                      input logic [15:0] to);
      cfg_wr = 1'b1; cfg_pat = p; cfg_len = l; cfg_tgt = t; cfg_to = to;
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      m_det = 0;
      if (!m_armed && !m_run && !m_done) begin
         m_pat = p;
         m_len = (l == 4'd0) ? 1 : ((int'(l) > PAT_W) ? PAT_W : int'(l));
         m_tgt = int'(t);
         m_to  = int'(to);
      end
      check_all("cfg");
   endtask

   task automatic arm();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_det = 0;
      if (!m_armed && !m_run && !m_done) begin
         m_armed = 1; m_hits = 0; m_beats = 0; m_hit = 0; m_tmo = 0; hist.delete();
      end
      check_all("arm");
      @(posedge clk); #1;
      if (m_armed) begin
         m_armed = 0; m_run = 1;
      end
      check_all("arm2");
   endtask

   task automatic cycle(input logic v, input logic b);
      int eff;
      in_vld = v; in = b;
      @(posedge clk); #1;
      in_vld = 1'b0; in = 1'b0;
      m_det = 0;
      eff = (m_tgt == 0) ? 1 : m_tgt;
      if (m_run && v) begin
         hist.push_back(b);
         if (hist.size() > 16) void'(hist.pop_front());
         m_beats++;
         if (model_match()) begin
            m_det = 1;
            if (m_hits != 255) m_hits++;
            if (m_hits == eff) begin
               m_run = 0; m_done = 1; m_hit = 1;
            end
         end
`ifdef SEQ_DET_TIMEOUT_EN
         if (m_run && m_to != 0 && m_beats == m_to) begin
            m_run = 0; m_done = 1; m_tmo = 1;
         end
`endif
      end
      check_all("cyc");
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      m_det = 0;
      if (m_done) m_done = 0;
      check_all("ack");
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      m_det = 0;
      if (m_armed || m_run) begin
         m_armed = 0; m_run = 0;
      end
      check_all("abort");
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i]);
   endtask

   initial begin
      do_reset();

      // default 111 pattern, target 1
      arm();
      send_bits(16'b111, 3);
      chk("t1.det", 32'(det), 32'd1);
      cycle(1'b1, 1'b1);            // DONE ignores input
      arm();                        // start in DONE ignored
      do_ack();

      // pattern 101 target 2 and ack outside DONE
      cfg(8'b101, 4'd3, 8'd2, 16'd0);
      arm();
      do_ack();
      send_bits(16'b10101, 5);
      chk("t2.hits", 32'(hit_cnt), 32'd2);
      do_ack();

      // overlapping matches
      cfg(8'b111, 4'd3, 8'd3, 16'd0);
      arm();
      send_bits(16'b11111, 5);
      do_ack();

`ifdef SEQ_DET_TIMEOUT_EN
      cfg(8'b111, 4'd3, 8'd1, 16'd4);
      arm();
      send_bits(16'b0000, 4);
      chk("to.tmo", 32'(tmo), 32'd1);
      do_ack();
      arm();
      send_bits(16'b0111, 4);
      chk("to.hit", 32'(hit), 32'd1);
      do_ack();
`endif

      // abort keeps hit_cnt; cfg_wr during RUN is ignored
      cfg(8'b111, 4'd3, 8'd2, 16'd0);
      arm();
      send_bits(16'b111, 3);
      cfg(8'b000, 4'd1, 8'd1, 16'd0);
      cycle(1'b1, 1'b0);
      do_abort();
      chk("ab.hits", 32'(hit_cnt), 32'd1);
      cycle(1'b1, 1'b1);

      // reset mid-run restores default configuration
      cfg(8'hF0, 4'd5, 8'd4, 16'd0);
      arm();
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      do_reset();
      arm();
      send_bits(16'b111, 3);
      do_ack();

      // length boundaries: 0 -> 1, 15 -> PAT_W, and target 0 treated as 1
      cfg(8'h01, 4'd0, 8'd0, 16'd0);
      arm();
      cycle(1'b1, 1'b1);
      chk("len1.done", 32'(done), 32'd1);
      do_ack();
      cfg(8'hA5, 4'd15, 8'd1, 16'd0);
      arm();
      send_bits(16'h00A5, 8);
      do_ack();

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         logic [7:0]  rp;
         logic [3:0]  rl;
         logic [7:0]  rt;
         logic [15:0] rto;
         rp  = 8'($urandom);
         rl  = (r % 5 == 4) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 3));
         rt  = 8'($urandom_range(0, 4));
         rto = 16'($urandom_range(0, 20));
         cfg(rp, rl, rt, rto);
         arm();
         for (int c = 0; c < 80 && !m_done; c++) begin
            logic v, b;
            v = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 2) != 0);
            cycle(v, b);
         end
         if (m_done) do_ack();
         else do_abort();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameters SHALL be: PAT_W, default 8, maximum pattern length in bits; CNT_W, default 8, match-counter width; TO_W, default 16, timeout-counter width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in  input  1  serial data bit.
REQ-005 in_vld  input  1  qualifies in; the bit is sampled only when in_vld=1.
REQ-006 cfg_wr  input  1  configuration write strobe.
REQ-007 cfg_pat  input  PAT_W  pattern bits; bit 0 is the last-received bit of the pattern.
REQ-008 cfg_len  input  4  pattern length.
REQ-009 cfg_tgt  input  CNT_W  number of matches required to finish.
REQ-010 cfg_to  input  TO_W  timeout in in_vld beats; 0 means no timeout.
REQ-011 start  input  1  arm pulse.
REQ-012 abort  input  1  abandon the run.
REQ-013 ack  input  1  acknowledges done.
REQ-014 busy  output  1  high in ARMED or RUN.
REQ-015 det  output  reg 1  one-cycle match pulse.
REQ-016 done  output  1  high in DONE.
REQ-017 hit  output  1  target reached; valid while done=1.
REQ-018 tmo  output  1  timeout occurred; valid while done=1.
REQ-019 hit_cnt  output  CNT_W  matches in the current or last run.

Function
REQ-020 The FSM SHALL have the states IDLE, ARMED, RUN and DONE.
REQ-021 IDLE->ARMED SHALL occur on start; start outside IDLE SHALL be ignored.
REQ-022 On entry to ARMED: clear the shift register, bit counter, hit_cnt and timeout counter; ARMED->RUN SHALL follow unconditionally on the next cycle.
REQ-023 In RUN, each in_vld beat SHALL shift in into the shift register LSB and increment the saturating bit counter.
REQ-024 A match SHALL be: bit counter >= len, and the low len bits of the shift register equal the low len bits of the pattern.
REQ-025 Matches SHALL overlap: pattern 111 on input 1111 yields two matches.
REQ-026 det SHALL pulse in the cycle after the edge that sampled the completing bit (latency 1); hit_cnt SHALL update on that same cycle.
REQ-027 hit_cnt SHALL saturate at all-ones.
REQ-028 When hit_cnt reaches cfg_tgt, RUN->DONE SHALL occur with hit=1.
REQ-029 A cfg_tgt of 0 SHALL be treated as 1.
REQ-030 DONE SHALL hold done=1 until ack; ack SHALL move the FSM to IDLE on the next cycle; ack outside DONE SHALL be ignored.
REQ-031 abort in ARMED or RUN SHALL force IDLE next cycle with no done, keeping hit_cnt; abort has priority over every other transition.
REQ-032 cfg_wr SHALL load pattern, len, target and timeout only in IDLE; it SHALL be ignored in other states.
REQ-033 len of 0 SHALL be stored as 1; len > PAT_W SHALL be stored as PAT_W.
REQ-034 In DONE, in/in_vld SHALL be ignored and det SHALL stay 0.

Reset
REQ-035 On rst: state=IDLE; det=0, done=0, hit=0, tmo=0, busy=0; hit_cnt=0.
REQ-036 On rst: pattern=3'b111 zero-extended; len=3; target=1; timeout=0.
REQ-037 rst mid-run SHALL abandon the run silently on the next edge.
REQ-038 rst SHALL dominate all inputs.

Configuration
REQ-039 The macro SEQ_DET_TIMEOUT_EN, when defined, SHALL enable the timeout feature.
REQ-040 With SEQ_DET_TIMEOUT_EN, each in_vld beat in RUN SHALL increment the timeout counter; when it equals a nonzero cfg_to without reaching target, RUN->DONE SHALL occur with tmo=1 and hit=0.
REQ-041 With SEQ_DET_TIMEOUT_EN, if a match reaches target on the same beat the counter reaches cfg_to, the match SHALL win: hit=1, tmo=0.
REQ-042 Without SEQ_DET_TIMEOUT_EN, the timeout counter and register SHALL not exist, cfg_to SHALL be ignored, and tmo SHALL be tied to 0.

Structure
REQ-043 Package seq_det_pkg SHALL hold the state encoding constants (IDLE=0, ARMED=1, RUN=2, DONE=3) and the reset pattern, length and target constants.
REQ-044 Sub-module seq_match SHALL hold the shift register, bit counter and match compare, with inputs clr, shift, bit, pat and len and output match; the FSM and counters SHALL stay in seq_det_ctrl.

Verification
REQ-045 Reset defaults, start, in=1,1,1 on consecutive in_vld beats -> det pulse 1 cycle after the third bit; hit_cnt=1; done=1, hit=1; ack -> IDLE.
REQ-046 cfg pattern=101, len=3, target=2; stream 1,0,1,0,1 -> det after bits 3 and 5; hit_cnt=2; DONE.
REQ-047 target=3, pattern 111; stream 1,1,1,1,1 -> 3 overlapping matches at bits 3, 4 and 5.
REQ-048 SEQ_DET_TIMEOUT_EN: cfg_to=4, target=1, pattern 111, stream 0,0,0,0 -> done with tmo=1, hit=0; stream 0,1,1,1 with cfg_to=4 -> hit=1, tmo=0.
REQ-049 abort during RUN with hit_cnt=1 -> IDLE next cycle, done never asserted, hit_cnt=1; cfg_wr during RUN -> configuration unchanged.
REQ-050 rst asserted mid-run with in_vld toggling -> all outputs at reset values next cycle; cfg_len=0 write -> len reads as 1; single 1 matches pattern bit 0.
